// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one access at a time through IDLE -> ACCESS -> RESP, big-endian lanes.
// Optional alignment checking is enabled by defining LSU_ALIGN_CHECK_EN.
module lsu_ctrl #(
  parameter int N_DATA = 32,
  parameter int N_ADDR = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [2:0]        i_req_op,
  input  logic [N_ADDR-1:0] i_req_addr,
  input  logic [N_DATA-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [N_DATA-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_ram_ce,
  output logic              o_ram_we,
  output logic [3:0]        o_ram_sel,
  output logic [N_ADDR-1:0] o_ram_addr,
  output logic [N_DATA-1:0] o_ram_data,
  input  logic [N_DATA-1:0] i_ram_data
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  typedef enum logic [2:0] {
    OP_LB = 3'b000, OP_LBU = 3'b001, OP_LH = 3'b010, OP_LHU = 3'b011,
    OP_LW = 3'b100, OP_SB  = 3'b101, OP_SH = 3'b110, OP_SW  = 3'b111
  } op_t;

  state_t            r_state, w_state_nxt;
  op_t               r_op;
  logic [N_ADDR-1:0] r_addr;
  logic [N_DATA-1:0] r_wdata;
  logic [N_DATA-1:0] r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_store;
  logic              w_is_byte;
  logic              w_is_half;
  logic              w_misalign;
  logic [3:0]        w_sel;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [N_DATA-1:0] w_load_data;
  logic [N_DATA-1:0] w_store_data;

  assign w_accept  = i_req_valid && (r_state == S_IDLE);
  assign w_store   = r_op inside {OP_SB, OP_SH, OP_SW};
  assign w_is_byte = r_op inside {OP_LB, OP_LBU, OP_SB};
  assign w_is_half = r_op inside {OP_LH, OP_LHU, OP_SH};

`ifdef LSU_ALIGN_CHECK_EN
  assign w_misalign = (w_is_half && r_addr[0]) ||
                      ((r_op inside {OP_LW, OP_SW}) && (r_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Lane decode and load extraction; byte offset 0 is the most significant byte.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_sel        = 4'b1111;
    w_store_data = r_wdata;
    w_byte       = i_ram_data[31:24];
    w_half       = r_addr[1] ? i_ram_data[15:0] : i_ram_data[31:16];
    case (r_addr[1:0])
      2'd0:    w_byte = i_ram_data[31:24];
      2'd1:    w_byte = i_ram_data[23:16];
      2'd2:    w_byte = i_ram_data[15:8];
      default: w_byte = i_ram_data[7:0];
    endcase
    if (w_is_byte) begin
      w_sel        = 4'b1000 >> r_addr[1:0];
      w_store_data = {4{r_wdata[7:0]}};
    end else if (w_is_half) begin
      w_sel        = r_addr[1] ? 4'b0011 : 4'b1100;
      w_store_data = {2{r_wdata[15:0]}};
    end
    case (r_op)
      OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load_data = {24'd0, w_byte};
      OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load_data = {16'd0, w_half};
      OP_LW:   w_load_data = i_ram_data;
      default: w_load_data = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      r_state <= w_state_nxt;
      if (r_state == S_ACCESS) begin
        r_rdata <= (w_store || w_misalign) ? '0 : w_load_data;
        r_err   <= w_misalign;
      end
    end
  end

  // NOTE: request capture registers carry no reset; they are only observed after an accept loads them.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_op    <= op_t'(i_req_op);
      r_addr  <= i_req_addr;
      r_wdata <= i_req_wdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = 1'b0;
    o_ram_ce    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_sel   = 4'b0000;
    o_ram_addr  = '0;
    o_ram_data  = '0;
    o_rsp_valid = 1'b0;
    o_rsp_rdata = '0;
    o_rsp_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        o_ram_ce    = !w_misalign;
        o_ram_we    = w_store && !w_misalign;
        o_ram_sel   = w_misalign ? 4'b0000 : w_sel;
        o_ram_addr  = {r_addr[N_ADDR-1:2], 2'b00};
        o_ram_data  = w_store_data;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_rdata = r_rdata;
        o_rsp_err   = r_err;
        if (i_rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
